// File: rtl/exu_wbck_rglr_if.sv
// rtl/exu_wbck_rglr_if.sv - ALU/LSU writeback channels and regfile write port bundle
interface exu_wbck_rglr_if #(
    parameter int XLEN        = 32,
    parameter int RFIDX_WIDTH = 5
);
    logic                   alu_wbck_i_valid;
    logic                   alu_wbck_i_ready;
    logic [XLEN-1:0]        alu_wbck_i_wdat;
    logic [RFIDX_WIDTH-1:0] alu_wbck_i_rdidx;
    logic                   alu_wbck_i_rdwen;
    logic                   alu_cmt_i_ebreak;

    logic                   lsu_wbck_i_valid;
    logic                   lsu_wbck_i_ready;
    logic [XLEN-1:0]        lsu_wbck_i_wdat;
    logic [RFIDX_WIDTH-1:0] lsu_wbck_i_rdidx;

    logic                   rf_wbck_o_ena;
    logic [RFIDX_WIDTH-1:0] rf_wbck_o_idx;
    logic [XLEN-1:0]        rf_wbck_o_wdat;

    modport master (
        output alu_wbck_i_valid, alu_wbck_i_wdat, alu_wbck_i_rdidx, alu_wbck_i_rdwen, alu_cmt_i_ebreak,
        output lsu_wbck_i_valid, lsu_wbck_i_wdat, lsu_wbck_i_rdidx,
        input  alu_wbck_i_ready, lsu_wbck_i_ready,
        input  rf_wbck_o_ena, rf_wbck_o_idx, rf_wbck_o_wdat
    );

    modport slave (
        input  alu_wbck_i_valid, alu_wbck_i_wdat, alu_wbck_i_rdidx, alu_wbck_i_rdwen, alu_cmt_i_ebreak,
        input  lsu_wbck_i_valid, lsu_wbck_i_wdat, lsu_wbck_i_rdidx,
        output alu_wbck_i_ready, lsu_wbck_i_ready,
        output rf_wbck_o_ena, rf_wbck_o_idx, rf_wbck_o_wdat
    );
endinterface

// File: rtl/exu_wbck_rglr.sv
// rtl/exu_wbck_rglr.sv - ALU/LSU writeback arbiter, regfile write, retire count and ebreak halt
module exu_wbck_rglr #(
    parameter int XLEN        = 32,
    parameter int RFIDX_WIDTH = 5,
    parameter int CNT_WIDTH   = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    exu_wbck_rglr_if.slave       wb,
    output logic                 cmt_o_halt,
    output logic [CNT_WIDTH-1:0] cmt_o_instret
);
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic                   ena_q, ena_d;
    logic [RFIDX_WIDTH-1:0] idx_q, idx_d;
    logic [XLEN-1:0]        wdat_q, wdat_d;
    logic [CNT_WIDTH-1:0]   instret_q, instret_d;

    logic halt;
    logic lsu_hs;
    logic alu_hs;

    // LSU has fixed priority; neither ready looks at its own valid.
    assign halt                = (state_q == ST_HALT);
    assign wb.lsu_wbck_i_ready = ~halt;
    assign wb.alu_wbck_i_ready = ~halt & ~wb.lsu_wbck_i_valid;
    assign lsu_hs              = wb.lsu_wbck_i_valid & wb.lsu_wbck_i_ready;
    assign alu_hs              = wb.alu_wbck_i_valid & wb.alu_wbck_i_ready;

    always_comb begin
        state_d   = state_q;
        ena_d     = 1'b0;
        idx_d     = idx_q;
        wdat_d    = wdat_q;
        instret_d = instret_q;
        if (lsu_hs) begin
            ena_d  = (wb.lsu_wbck_i_rdidx != '0);
            idx_d  = wb.lsu_wbck_i_rdidx;
            wdat_d = wb.lsu_wbck_i_wdat;
        end else if (alu_hs) begin
            ena_d  = wb.alu_wbck_i_rdwen & (wb.alu_wbck_i_rdidx != '0);
            idx_d  = wb.alu_wbck_i_rdidx;
            wdat_d = wb.alu_wbck_i_wdat;
            if (wb.alu_cmt_i_ebreak) begin
                state_d = ST_HALT;
            end
        end
        if (lsu_hs | alu_hs) begin
            instret_d = instret_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            ena_q     <= 1'b0;
            idx_q     <= '0;
            wdat_q    <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            ena_q     <= ena_d;
            idx_q     <= idx_d;
            wdat_q    <= wdat_d;
            instret_q <= instret_d;
        end
    end

    assign wb.rf_wbck_o_ena  = ena_q;
    assign wb.rf_wbck_o_idx  = idx_q;
    assign wb.rf_wbck_o_wdat = wdat_q;
    assign cmt_o_halt        = halt;
    assign cmt_o_instret     = instret_q;
endmodule

// File: tb/tb_exu_wbck_rglr.sv
// tb/tb_exu_wbck_rglr.sv - randomized and directed bench for exu_wbck_rglr against a retire model
module tb_exu_wbck_rglr;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    exu_wbck_rglr_if #(.XLEN(32), .RFIDX_WIDTH(5)) ifa ();
    exu_wbck_rglr_if #(.XLEN(32), .RFIDX_WIDTH(5)) ifs ();

    logic        halt_a, halt_s;
    logic [63:0] instret_a;
    logic [3:0]  instret_s;

    exu_wbck_rglr #(.XLEN(32), .RFIDX_WIDTH(5), .CNT_WIDTH(64)) dut (
        .clk(clk), .rst_n(rst_n), .wb(ifa.slave), .cmt_o_halt(halt_a), .cmt_o_instret(instret_a)
    );
    exu_wbck_rglr #(.XLEN(32), .RFIDX_WIDTH(5), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .wb(ifs.slave), .cmt_o_halt(halt_s), .cmt_o_instret(instret_s)
    );

    // Narrow-counter copy sees exactly the same stimulus.
    assign ifs.alu_wbck_i_valid = ifa.alu_wbck_i_valid;
    assign ifs.alu_wbck_i_wdat  = ifa.alu_wbck_i_wdat;
    assign ifs.alu_wbck_i_rdidx = ifa.alu_wbck_i_rdidx;
    assign ifs.alu_wbck_i_rdwen = ifa.alu_wbck_i_rdwen;
    assign ifs.alu_cmt_i_ebreak = ifa.alu_cmt_i_ebreak;
    assign ifs.lsu_wbck_i_valid = ifa.lsu_wbck_i_valid;
    assign ifs.lsu_wbck_i_wdat  = ifa.lsu_wbck_i_wdat;
    assign ifs.lsu_wbck_i_rdidx = ifa.lsu_wbck_i_rdidx;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    endtask

    // Reference model: what the write port and commit outputs must show after the coming edge.
    logic        m_halt;
    logic        m_ena;
    logic [4:0]  m_idx;
    logic [31:0] m_wdat;
    logic [63:0] m_cnt;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_halt = 1'b0; m_ena = 1'b0; m_idx = '0; m_wdat = '0; m_cnt = '0;
        end
        chk("ena",       {63'd0, ifa.rf_wbck_o_ena}, {63'd0, m_ena});
        chk("idx",       {59'd0, ifa.rf_wbck_o_idx}, {59'd0, m_idx});
        chk("wdat",      {32'd0, ifa.rf_wbck_o_wdat}, {32'd0, m_wdat});
        chk("halt",      {63'd0, halt_a}, {63'd0, m_halt});
        chk("instret",   instret_a, m_cnt);
        chk("instret4",  {60'd0, instret_s}, m_cnt % 64'd16);
        chk("ena4",      {63'd0, ifs.rf_wbck_o_ena}, {63'd0, m_ena});
        chk("halt4",     {63'd0, halt_s}, {63'd0, m_halt});
        chk("lsu_ready", {63'd0, ifa.lsu_wbck_i_ready}, {63'd0, !m_halt});
        chk("alu_ready", {63'd0, ifa.alu_wbck_i_ready}, {63'd0, !m_halt && !ifa.lsu_wbck_i_valid});
        m_ena = 1'b0;
        if (rst_n && !m_halt) begin
            if (ifa.lsu_wbck_i_valid) begin
                m_ena  = ifa.lsu_wbck_i_rdidx != 5'd0;
                m_idx  = ifa.lsu_wbck_i_rdidx;
                m_wdat = ifa.lsu_wbck_i_wdat;
                m_cnt  = m_cnt + 64'd1;
            end else if (ifa.alu_wbck_i_valid) begin
                m_ena  = ifa.alu_wbck_i_rdwen && ifa.alu_wbck_i_rdidx != 5'd0;
                m_idx  = ifa.alu_wbck_i_rdidx;
                m_wdat = ifa.alu_wbck_i_wdat;
                m_cnt  = m_cnt + 64'd1;
                if (ifa.alu_cmt_i_ebreak) m_halt = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifa.alu_wbck_i_valid = 1'b0; ifa.alu_wbck_i_wdat = '0; ifa.alu_wbck_i_rdidx = '0;
        ifa.alu_wbck_i_rdwen = 1'b0; ifa.alu_cmt_i_ebreak = 1'b0;
        ifa.lsu_wbck_i_valid = 1'b0; ifa.lsu_wbck_i_wdat = '0; ifa.lsu_wbck_i_rdidx = '0;
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        idle_inputs();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic set_alu(input logic [31:0] d, input logic [4:0] i, input logic we, input logic eb);
        ifa.alu_wbck_i_valid = 1'b1; ifa.alu_wbck_i_wdat = d; ifa.alu_wbck_i_rdidx = i;
        ifa.alu_wbck_i_rdwen = we; ifa.alu_cmt_i_ebreak = eb;
    endtask

    // One random cycle; a stalled ALU keeps its whole payload.
    task automatic drive_rand(input int ebr_den);
        logic stalled;
        stalled = ifa.alu_wbck_i_valid && ifa.lsu_wbck_i_valid;
        step();
        if (!stalled) begin
            ifa.alu_wbck_i_valid = $urandom_range(0, 1) != 0;
            ifa.alu_wbck_i_wdat  = $urandom;
            ifa.alu_wbck_i_rdidx = 5'($urandom_range(0, 31));
            ifa.alu_wbck_i_rdwen = $urandom_range(0, 3) != 0;
            ifa.alu_cmt_i_ebreak = $urandom_range(0, ebr_den - 1) == 0;
        end
        ifa.lsu_wbck_i_valid = $urandom_range(0, 2) == 0;
        ifa.lsu_wbck_i_wdat  = $urandom;
        ifa.lsu_wbck_i_rdidx = 5'($urandom_range(0, 31));
    endtask

    initial begin
        idle_inputs();
        do_reset();

        set_alu(32'h0000_1234, 5'd5, 1'b1, 1'b0);
        @(negedge clk);
        chk("t1_alu_ready", {63'd0, ifa.alu_wbck_i_ready}, 64'd1);
        step();
        ifa.alu_wbck_i_valid = 1'b0;
        @(negedge clk);
        chk("t1_ena", {63'd0, ifa.rf_wbck_o_ena}, 64'd1);
        chk("t1_idx", {59'd0, ifa.rf_wbck_o_idx}, 64'd5);
        chk("t1_wdat", {32'd0, ifa.rf_wbck_o_wdat}, 64'h1234);
        chk("t1_instret", instret_a, 64'd1);
        step();
        @(negedge clk);
        chk("t1_ena_drop", {63'd0, ifa.rf_wbck_o_ena}, 64'd0);

        step();
        set_alu(32'h5, 5'd8, 1'b1, 1'b0);
        ifa.lsu_wbck_i_valid = 1'b1; ifa.lsu_wbck_i_wdat = 32'hAAAA_0000; ifa.lsu_wbck_i_rdidx = 5'd7;
        @(negedge clk);
        chk("t2_lsu_ready", {63'd0, ifa.lsu_wbck_i_ready}, 64'd1);
        chk("t2_alu_ready", {63'd0, ifa.alu_wbck_i_ready}, 64'd0);
        step();
        ifa.lsu_wbck_i_valid = 1'b0;
        @(negedge clk);
        chk("t2_idx7", {59'd0, ifa.rf_wbck_o_idx}, 64'd7);
        chk("t2_wdat7", {32'd0, ifa.rf_wbck_o_wdat}, 64'hAAAA_0000);
        step();
        ifa.alu_wbck_i_valid = 1'b0;
        @(negedge clk);
        chk("t2_idx8", {59'd0, ifa.rf_wbck_o_idx}, 64'd8);
        chk("t2_ena8", {63'd0, ifa.rf_wbck_o_ena}, 64'd1);
        chk("t2_instret", instret_a, 64'd3);

        step();
        set_alu(32'hFF, 5'd0, 1'b1, 1'b0);
        step();
        ifa.alu_wbck_i_valid = 1'b0;
        @(negedge clk);
        chk("t3_x0_ena", {63'd0, ifa.rf_wbck_o_ena}, 64'd0);
        chk("t3_instret", instret_a, 64'd4);

        step();
        set_alu(32'h0, 5'd3, 1'b0, 1'b1);
        step();
        set_alu(32'h9, 5'd9, 1'b1, 1'b0);
        ifa.lsu_wbck_i_valid = 1'b1; ifa.lsu_wbck_i_rdidx = 5'd10;
        @(negedge clk);
        chk("t4_halt", {63'd0, halt_a}, 64'd1);
        chk("t4_ena", {63'd0, ifa.rf_wbck_o_ena}, 64'd0);
        chk("t4_alu_ready", {63'd0, ifa.alu_wbck_i_ready}, 64'd0);
        chk("t4_lsu_ready", {63'd0, ifa.lsu_wbck_i_ready}, 64'd0);
        repeat (3) step();
        @(negedge clk);
        chk("t4_frozen", instret_a, 64'd5);
        chk("t4_no_write", {63'd0, ifa.rf_wbck_o_ena}, 64'd0);

        do_reset();
        set_alu(32'h1, 5'd1, 1'b1, 1'b0);
        repeat (16) step();
        ifa.alu_wbck_i_valid = 1'b0;
        @(negedge clk);
        chk("t5_wrap4", {60'd0, instret_s}, 64'd0);
        chk("t5_count64", instret_a, 64'd16);

        do_reset();
        set_alu(32'h77, 5'd9, 1'b1, 1'b1);
        step();
        ifa.alu_wbck_i_valid = 1'b0; ifa.alu_cmt_i_ebreak = 1'b0;
        chk("t6_halt_pre", {63'd0, halt_a}, 64'd1);
        chk("t6_ena_pre", {63'd0, ifa.rf_wbck_o_ena}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_halt", {63'd0, halt_a}, 64'd0);
        chk("t6_async_ena", {63'd0, ifa.rf_wbck_o_ena}, 64'd0);
        chk("t6_async_idx", {59'd0, ifa.rf_wbck_o_idx}, 64'd0);
        chk("t6_async_wdat", {32'd0, ifa.rf_wbck_o_wdat}, 64'd0);
        chk("t6_async_cnt", instret_a, 64'd0);
        step();
        rst_n = 1'b1;
        set_alu(32'h44, 5'd4, 1'b1, 1'b0);
        step();
        ifa.alu_wbck_i_valid = 1'b0;
        @(negedge clk);
        chk("t6_resume_ena", {63'd0, ifa.rf_wbck_o_ena}, 64'd1);
        chk("t6_resume_cnt", instret_a, 64'd1);

        for (int seg = 0; seg < 6; seg++) begin
            do_reset();
            repeat (250) drive_rand(30 + seg * 40);
        end

        step();
        idle_inputs();
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
